// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature snapshot readout block.
// Feature macro: QUAD_INDEX_ARM_EN selects armed index capture in quad_idx_arm.
package quad_pkg;

  localparam int unsigned CW_DEF   = 14;
  localparam int unsigned NCH_DEF  = 4;
  localparam int unsigned SEEN_BIT = 7;

  localparam logic [1:0] CNT_LO = 2'd0;
  localparam logic [1:0] CNT_HI = 2'd1;
  localparam logic [1:0] IDX_LO = 2'd2;
  localparam logic [1:0] IDX_HI = 2'd3;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    SEEN     = 2'd2
  } chan_state_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } top_state_t;

  // High byte of a 14-bit value; bits above the value width read as zero.
  function automatic logic [7:0] hi_byte(input logic [13:0] v);
    return {2'b00, v[13:8]};
  endfunction

endpackage

// File: rtl/quad_idx_arm.sv
// Per-channel index tracking: edge detect plus armed capture FSM or sticky flag.
// Feature macro: QUAD_INDEX_ARM_EN selects the armed-capture variant.
module quad_idx_arm
  import quad_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          idx_evt,
  input  logic          arm,
  input  logic          clr,
  input  logic [CW-1:0] idx_in,
  output logic          seen,
  output logic [CW-1:0] idx_rep_c
);

  logic evt_q;
  logic edge_c;

  assign edge_c = idx_evt & ~evt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_q <= 1'b0;
    else        evt_q <= idx_evt;
  end

`ifdef QUAD_INDEX_ARM_EN
  chan_state_t   state;
  logic [CW-1:0] held;
  logic          unused_clr;

  assign unused_clr = clr;
  assign idx_rep_c  = held;

  // Arm has priority over a coincident edge; snapshots never clear SEEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DISARMED;
      held  <= '0;
      seen  <= 1'b0;
    end else if (arm) begin
      state <= ARMED;
      seen  <= 1'b0;
    end else if (state == ARMED && edge_c) begin
      state <= SEEN;
      seen  <= 1'b1;
      held  <= idx_in;
    end
  end
`else
  logic unused_arm;

  assign unused_arm = arm;
  assign idx_rep_c  = idx_in;

  // Sticky flag: a new edge outranks the snapshot clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      seen <= 1'b0;
    else if (edge_c) seen <= 1'b1;
    else if (clr)    seen <= 1'b0;
  end
`endif

endmodule

// File: rtl/quad_snap_ctl.sv
// Snapshot and byte-serial readout of quadrature count/index values.
// Feature macro: QUAD_INDEX_ARM_EN (armed index capture in quad_idx_arm).
module quad_snap_ctl
  import quad_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned CW  = CW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*CW-1:0] cnt_in,
  input  logic [NCH*CW-1:0] idx_in,
  input  logic [NCH-1:0]    idx_evt,
  input  logic [NCH-1:0]    arm,
  input  logic              snap_req,
  input  logic              rd_stb,
  output logic [7:0]        rd_data,
  output logic              rd_last,
  output logic              snap_busy,
  output logic [NCH-1:0]    idx_seen
);

  localparam int unsigned NB = 4 * NCH;
  localparam int unsigned PW = $clog2(NB);
  localparam logic [PW-1:0] LAST = PW'(NB - 1);

  top_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt_c;
  logic [PW-1:0] ch_c;
  logic [7:0]    byte_c;
  logic [CW-1:0] cnt_sh    [NCH];
  logic [CW-1:0] idx_sh    [NCH];
  logic [CW-1:0] idx_rep_c [NCH];
  logic [NCH-1:0] seen_sh;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    quad_idx_arm #(.CW(CW)) u_idx (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx_evt   (idx_evt[k]),
      .arm       (arm[k]),
      .clr       (snap_req),
      .idx_in    (idx_in[k*CW +: CW]),
      .seen      (idx_seen[k]),
      .idx_rep_c (idx_rep_c[k])
    );
  end

  assign ptr_nxt_c = ptr + PW'(1);
  assign ch_c      = ptr_nxt_c >> 2;

  // Byte the pointer will select after an advancing strobe.
  always_comb begin
    byte_c = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_c == PW'(k)) begin
        case (ptr_nxt_c[1:0])
          CNT_LO: byte_c = cnt_sh[k][7:0];
          CNT_HI: begin
            byte_c           = hi_byte(14'(cnt_sh[k]));
            byte_c[SEEN_BIT] = seen_sh[k];
          end
          IDX_LO: byte_c = idx_sh[k][7:0];
          IDX_HI: byte_c = hi_byte(14'(idx_sh[k]));
          default: byte_c = '0;
        endcase
      end
    end
  end

  // Snapshot request outranks a coincident strobe and restarts readout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      snap_busy <= 1'b0;
      seen_sh   <= '0;
      for (int k = 0; k < NCH; k++) begin
        cnt_sh[k] <= '0;
        idx_sh[k] <= '0;
      end
    end else if (snap_req) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_sh[k] <= cnt_in[k*CW +: CW];
        idx_sh[k] <= idx_rep_c[k];
      end
      seen_sh   <= idx_seen;
      state     <= SERVE;
      ptr       <= '0;
      rd_data   <= cnt_in[7:0];
      rd_last   <= 1'b0;
      snap_busy <= 1'b1;
    end else begin
      case (state)
        IDLE: ;
        SERVE: begin
          if (rd_stb) begin
            if (rd_last) begin
              state     <= IDLE;
              ptr       <= '0;
              rd_data   <= '0;
              rd_last   <= 1'b0;
              snap_busy <= 1'b0;
            end else begin
              ptr     <= ptr_nxt_c;
              rd_data <= byte_c;
              rd_last <= (ptr_nxt_c == LAST);
            end
          end
        end
        default: begin
          state     <= IDLE;
          snap_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
